// File: rtl/write_back_regfile_if.sv
// write_back_regfile_if: pipeline-side bundle of EX/DM/ID signals and write-back observation outputs
interface write_back_regfile_if #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3
);
  logic [DATA_W-1:0] ans_dm;
  logic [REG_AW-1:0] rd_ex;
  logic              reg_we_ex;
  logic              mem_rd_ex;
  logic [REG_AW-1:0] rs1_id;
  logic [REG_AW-1:0] rs2_id;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              load_stall;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  modport master (
    output ans_dm, rd_ex, reg_we_ex, mem_rd_ex, rs1_id, rs2_id,
    input  rs1_data, rs2_data, load_stall, wb_valid, wb_addr, wb_data
  );
  modport slave (
    input  ans_dm, rd_ex, reg_we_ex, mem_rd_ex, rs1_id, rs2_id,
    output rs1_data, rs2_data, load_stall, wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/write_back_regfile.sv
// write_back_regfile: write-back stage + 8-entry regfile with load-use hazard flag; RF_BYPASS_EN enables write-through reads
module write_back_regfile #(
  parameter int DATA_W  = 8,
  parameter int REG_AW  = 3,
  parameter int R0_ZERO = 1
) (
  input logic               clk,
  input logic               reset,
  write_back_regfile_if.slave bus
);
  localparam int NREG = 1 << REG_AW;
  logic [DATA_W-1:0] regs_q [NREG];
  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_addr_q;
  logic              rd_ok_ex;
  assign rd_ok_ex   = (bus.rd_ex != '0) || (R0_ZERO == 0);
  assign wb_valid_d = bus.reg_we_ex & rd_ok_ex;
  // stage register: align EX tag/enable with ans_dm one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= bus.rd_ex;
    end
  end
  // register file write port; ans_dm only captured on a committing write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_valid_q) begin
      regs_q[wb_addr_q] <= bus.ans_dm;
    end
  end
  function automatic logic [DATA_W-1:0] rd_port(input logic [REG_AW-1:0] a);
`ifdef RF_BYPASS_EN
    if (wb_valid_q && wb_addr_q == a) return bus.ans_dm;
`endif
    return (R0_ZERO != 0 && a == '0) ? '0 : regs_q[a];
  endfunction
  assign bus.rs1_data   = rd_port(bus.rs1_id);
  assign bus.rs2_data   = rd_port(bus.rs2_id);
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_addr    = wb_addr_q;
  assign bus.wb_data    = bus.ans_dm;
  assign bus.load_stall = bus.mem_rd_ex & bus.reg_we_ex & rd_ok_ex &
                          (bus.rd_ex == bus.rs1_id || bus.rd_ex == bus.rs2_id);
endmodule

// File: tb/tb_write_back_regfile.sv
// tb_write_back_regfile: directed-vector bench for write_back_regfile
module tb_write_back_regfile;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  write_back_regfile_if #(.DATA_W(8), .REG_AW(3)) bus ();
  write_back_regfile #(.DATA_W(8), .REG_AW(3), .R0_ZERO(1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.ans_dm = 8'h00; bus.rd_ex = 3'd0; bus.reg_we_ex = 1'b0; bus.mem_rd_ex = 1'b0;
    bus.rs1_id = 3'd0; bus.rs2_id = 3'd0;
    step();
    reset = 1'b1;
    bus.rd_ex = 3'd3; bus.reg_we_ex = 1'b1;
    step();
    bus.reg_we_ex = 1'b0; bus.rd_ex = 3'd0; bus.ans_dm = 8'h77;
    #1;
    check("pending_wb_valid", bus.wb_valid, 1);
    check("pending_wb_addr", bus.wb_addr, 3);
    reset = 1'b0;
    #1;
    check("async_rst_wb_valid", bus.wb_valid, 0);
    check("async_rst_wb_addr", bus.wb_addr, 0);
    step();
    reset = 1'b1;
    bus.ans_dm = 8'h00;
    step();
    for (int i = 0; i < 8; i++) begin
      bus.rs1_id = 3'(i); bus.rs2_id = 3'(i);
      #1;
      check($sformatf("rst_r%0d_p1", i), bus.rs1_data, 0);
      check($sformatf("rst_r%0d_p2", i), bus.rs2_data, 0);
    end
    bus.rd_ex = 3'd3; bus.reg_we_ex = 1'b1; bus.rs1_id = 3'd3;
    step();
    bus.rd_ex = 3'd0; bus.reg_we_ex = 1'b0; bus.ans_dm = 8'hA5;
    #1;
    check("wr3_wb_valid", bus.wb_valid, 1);
    check("wr3_wb_addr", bus.wb_addr, 3);
    check("wr3_wb_data", bus.wb_data, 8'hA5);
`ifdef RF_BYPASS_EN
    check("wr3_bypass_same_cycle", bus.rs1_data, 8'hA5);
`else
    check("wr3_old_same_cycle", bus.rs1_data, 8'h00);
`endif
    step();
    bus.ans_dm = 8'h00;
    #1;
    check("wr3_visible", bus.rs1_data, 8'hA5);
    check("wr3_wb_valid_drop", bus.wb_valid, 0);
    bus.rd_ex = 3'd0; bus.reg_we_ex = 1'b1;
    step();
    bus.reg_we_ex = 1'b0; bus.ans_dm = 8'hFF; bus.rs1_id = 3'd0;
    #1;
    check("r0_wb_valid", bus.wb_valid, 0);
    check("r0_read_same", bus.rs1_data, 0);
    step();
    bus.ans_dm = 8'h00;
    #1;
    check("r0_read_after", bus.rs1_data, 0);
    bus.mem_rd_ex = 1'b1; bus.reg_we_ex = 1'b1; bus.rd_ex = 3'd5; bus.rs1_id = 3'd1; bus.rs2_id = 3'd5;
    #1; check("lu_rs2_hit", bus.load_stall, 1);
    bus.rs1_id = 3'd5; bus.rs2_id = 3'd0;
    #1; check("lu_rs1_hit", bus.load_stall, 1);
    bus.rs1_id = 3'd4; bus.rs2_id = 3'd6;
    #1; check("lu_no_hit", bus.load_stall, 0);
    bus.rd_ex = 3'd0; bus.rs1_id = 3'd0; bus.rs2_id = 3'd0;
    #1; check("lu_r0", bus.load_stall, 0);
    bus.rd_ex = 3'd5; bus.rs1_id = 3'd5; bus.reg_we_ex = 1'b0;
    #1; check("lu_no_we", bus.load_stall, 0);
    bus.reg_we_ex = 1'b1; bus.mem_rd_ex = 1'b0;
    #1; check("lu_not_load", bus.load_stall, 0);
    bus.reg_we_ex = 1'b0; bus.rd_ex = 3'd0;
    step();
    bus.rd_ex = 3'd2; bus.reg_we_ex = 1'b1;
    step();
    bus.ans_dm = 8'h11;
    step();
    bus.ans_dm = 8'h22; bus.reg_we_ex = 1'b0; bus.rd_ex = 3'd0;
    step();
    bus.ans_dm = 8'h00; bus.rs1_id = 3'd2; bus.rs2_id = 3'd1;
    #1;
    check("b2b_r2_last", bus.rs1_data, 8'h22);
    check("b2b_r1_unchanged", bus.rs2_data, 8'h00);
    bus.rs2_id = 3'd3;
    #1;
    check("b2b_r3_unchanged", bus.rs2_data, 8'hA5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
